// File: rtl/sync_fifo_fwft.sv
// Synchronous single-clock FIFO with optional first-word-fall-through read port.
//
// Parameters:
//   G_WIDTH  - data word width in bits
//   G_DEPTH  - number of entries (power of two, >= 2)
//   G_FWFT   - 0: registered read data, 1: head word shown combinationally
//   G_AF_LVL - almost-full threshold (count >= G_AF_LVL)
//   G_AE_LVL - almost-empty threshold (count <= G_AE_LVL)
//
// Ports:
//   i_clk, i_rst           - clock, asynchronous active-high reset
//   i_wr, i_data           - write request and data
//   i_rd                   - read request
//   o_data, o_valid        - read data and its valid flag
//   o_full, o_empty        - occupancy status
//   o_almost_full/_empty   - threshold status
//   o_overflow/_underflow  - one-cycle pulses for rejected write/read
//   o_count                - current occupancy
module sync_fifo_fwft #(
  parameter int unsigned G_WIDTH  = 8,
  parameter int unsigned G_DEPTH  = 16,
  parameter int unsigned G_FWFT   = 0,
  parameter int unsigned G_AF_LVL = G_DEPTH - 2,
  parameter int unsigned G_AE_LVL = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr,
  input  logic                       i_rd,
  input  logic [G_WIDTH-1:0]         i_data,
  output logic [G_WIDTH-1:0]         o_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic                       o_overflow,
  output logic                       o_underflow,
  output logic [$clog2(G_DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(G_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(G_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(G_AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(G_AE_LVL);

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, unf_q;
  logic               full, empty, rd_acc, wr_acc;

  always_comb begin
    full   = (count_q == DEPTH_C);
    empty  = (count_q == '0);
    rd_acc = i_rd & ~empty;
    // A write into a full FIFO is fine when the head is leaving this cycle.
    wr_acc = i_wr & (~full | rd_acc);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      // Pointers are exactly log2(depth) bits, so they wrap on their own.
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= i_wr & ~wr_acc;
      unf_q   <= i_rd & ~rd_acc;
    end
  end

  // Storage is not reset; writes are blocked while reset is held.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !i_rst) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  if (G_FWFT != 0) begin : g_fwft
    assign o_data  = mem_q[rd_ptr_q];
    assign o_valid = ~empty;
  end else begin : g_std
    logic [G_WIDTH-1:0] data_q;
    logic               valid_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) data_q <= mem_q[rd_ptr_q];
      end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
  end

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count_q >= AF_C);
  assign o_almost_empty = (count_q <= AE_C);
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;
  assign o_count        = count_q;

endmodule
